// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (16-bit word count, then little-endian
// 32-bit words) and writes it into instruction memory while holding the core in
// reset. Releases the core only after a complete, well-formed load.
module prog_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   n_q;
  logic [AW-1:0] widx_q;
  logic [1:0]    bidx_q;
  logic [23:0]   part_q;

  logic          accept;
  logic          start_taken;
  logic          last_word;
  logic [15:0]   n_hdr;
  logic [31:0]   word;

  assign accept      = byte_valid & byte_ready;
  assign start_taken = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  // Full word count as it will be once the high header byte is taken.
  assign n_hdr       = {byte_data, n_q[7:0]};
  // Completed word: the incoming byte is always the most significant one.
  assign word        = {byte_data, part_q};
  // n_q is never zero while in StData, so the subtraction cannot underflow.
  assign last_word   = (32'(widx_q) == (32'(n_q) - 32'd1));

  // Status outputs decode directly from the registered state.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      StHdrLo, StHdrHi, StData: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StHdrLo;
      StHdrLo: if (accept) state_d = StHdrHi;
      StHdrHi: begin
        if (accept) begin
          if ((n_hdr == 16'd0) || (32'(n_hdr) > DEPTH)) state_d = StErr;
          else                                           state_d = StData;
        end
      end
      StData:  if (accept && (bidx_q == 2'd3) && last_word) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Header capture, word assembly, memory write port and core reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      part_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      // Rises one cycle after entering StDone; drops on the edge start is taken.
      core_rst_n <= (state_q == StDone) && (state_d == StDone);
      if (start_taken) begin
        n_q    <= '0;
        widx_q <= '0;
        bidx_q <= '0;
      end
      if (accept) begin
        case (state_q)
          StHdrLo: n_q[7:0]  <= byte_data;
          StHdrHi: n_q[15:8] <= byte_data;
          StData: begin
            if (bidx_q == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= widx_q;
              imem_wdata <= word;
              bidx_q     <= 2'd0;
              // Hold the index on the last word so it never reaches DEPTH.
              if (!last_word) widx_q <= widx_q + 1'b1;
            end else begin
              part_q[{bidx_q, 3'b000} +: 8] <= byte_data;
              bidx_q                       <= bidx_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, throttled, bad-header, reset-abort,
// start-ignore and full-depth loads, with a write log captured on the falling edge.
module tb_prog_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int last_acc = -1;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];
  logic [7:0]    bs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write pulse and the cycle of the latest accepted byte.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (byte_valid && byte_ready) last_acc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic put_word(input logic [31:0] w);
    bs.push_back(w[7:0]);
    bs.push_back(w[15:8]);
    bs.push_back(w[23:16]);
    bs.push_back(w[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = byte_ready;
      tick();
    end
    if (!taken) check("byte_timeout", 32'd0, 32'd1);
  endtask

  // Sends bs; throttled mode drops byte_valid for one cycle after each byte.
  task automatic send_stream(input bit throttle);
    foreach (bs[i]) begin
      send_byte(bs[i]);
      if (throttle) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic two_word_stream();
    bs.delete();
    bs.push_back(8'h02);
    bs.push_back(8'h00);
    put_word(32'h00A00513);
    put_word(32'h00B00593);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wa.size(), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, 32'(wa[0]), 32'd0);
      check({tag, "_d0"}, wd[0], 32'h00A00513);
      check({tag, "_a1"}, 32'(wa[1]), 32'd1);
      check({tag, "_d1"}, wd[1], 32'h00B00593);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_crstn"}, 32'(core_rst_n), 32'd0);
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,      32'd0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b   = 8'(i);
    pat = {b, ~b, 8'h5A, b ^ 8'hC3};
  endfunction

  initial begin
    int acc;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Two-word load, continuous bytes.
    clear_log();
    two_word_stream();
    pulse_start();
    check("t1_busy",  32'(busy),       32'd1);
    check("t1_ready", 32'(byte_ready), 32'd1);
    send_stream(1'b0);
    check("t1_we",    32'(imem_we),    32'd1);
    check("t1_addr",  32'(imem_addr),  32'd1);
    check("t1_wdata", imem_wdata,      32'h00B00593);
    check("t1_done",  32'(done),       32'd1);
    check("t1_crstn_early", 32'(core_rst_n), 32'd0);
    tick();
    check("t1_crstn", 32'(core_rst_n), 32'd1);
    check("t1_we_off", 32'(imem_we),   32'd0);
    check_two_writes("t1");

    // Bad headers: N = 0, then N = DEPTH + 1.
    clear_log();
    pulse_start();
    check("t2_crstn_drop", 32'(core_rst_n), 32'd0);
    bs.delete();
    bs.push_back(8'h00);
    bs.push_back(8'h00);
    send_stream(1'b0);
    check("t2_err0",   32'(err),        32'd1);
    check("t2_ready0", 32'(byte_ready), 32'd0);
    check("t2_crstn0", 32'(core_rst_n), 32'd0);
    tick();
    tick();
    check("t2_err0_hold", 32'(err),  32'd1);
    check("t2_busy0",     32'(busy), 32'd0);
    pulse_start();
    check("t2_restart", 32'(err), 32'd0);
    bs.delete();
    bs.push_back(8'h01);
    bs.push_back(8'h01);
    send_stream(1'b0);
    check("t2_err257",   32'(err),        32'd1);
    check("t2_ready257", 32'(byte_ready), 32'd0);
    check("t2_crstn257", 32'(core_rst_n), 32'd0);
    tick();
    check("t2_nwr", wa.size(), 32'd0);

    // Throttled stream: same result as continuous.
    clear_log();
    two_word_stream();
    pulse_start();
    send_stream(1'b1);
    tick();
    check("t3_done",  32'(done),       32'd1);
    check("t3_crstn", 32'(core_rst_n), 32'd1);
    check_two_writes("t3");

    // Reset after two bytes of word 0, then a full reload.
    clear_log();
    bs.delete();
    bs.push_back(8'h02);
    bs.push_back(8'h00);
    bs.push_back(8'h13);
    bs.push_back(8'h05);
    pulse_start();
    send_stream(1'b0);
    check("t4_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t4_rst");
    tick();
    tick();
    check("t4_nwr", wa.size(), 32'd0);
    two_word_stream();
    pulse_start();
    send_stream(1'b0);
    tick();
    check("t4_crstn", 32'(core_rst_n), 32'd1);
    check_two_writes("t4");

    // start during DATA is ignored; start in DONE restarts.
    clear_log();
    bs.delete();
    bs.push_back(8'h02);
    bs.push_back(8'h00);
    bs.push_back(8'h13);
    bs.push_back(8'h05);
    pulse_start();
    send_stream(1'b0);
    start = 1'b1;
    send_byte(8'hA0);
    start = 1'b0;
    bs.delete();
    bs.push_back(8'h00);
    put_word(32'h00B00593);
    send_stream(1'b0);
    tick();
    check("t5_done",  32'(done),       32'd1);
    check("t5_crstn", 32'(core_rst_n), 32'd1);
    check_two_writes("t5");
    pulse_start();
    check("t5_crstn_drop", 32'(core_rst_n), 32'd0);
    check("t5_busy",       32'(busy),       32'd1);
    check("t5_done_clr",   32'(done),       32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Full-depth load: N = 256.
    clear_log();
    bs.delete();
    bs.push_back(8'h00);
    bs.push_back(8'h01);
    for (int i = 0; i < 256; i++) put_word(pat(i));
    pulse_start();
    send_stream(1'b0);
    acc = last_acc;
    check("t6_done", 32'(done), 32'd1);
    tick();
    check("t6_crstn", 32'(core_rst_n), 32'd1);
    check("t6_nwr",   wa.size(),       32'd256);
    if (wa.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check($sformatf("t6_a%0d", i), 32'(wa[i]), 32'(i));
        check($sformatf("t6_d%0d", i), wd[i], pat(i));
      end
      check("t6_last_lat", 32'(wc[255]), 32'(acc + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
